mem_access_unit: RTL and testbench

//  Load/store sequencer: initiator side of the single-port data-memory interface (DataMem).

---
 rtl/mem_access_pkg.sv | 10 +
 rtl/mem_access_unit.sv | 101 ++++++++++
 tb/tb_mem_access_unit.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_pkg.sv
// Shared types for the load/store sequencer.
package mem_access_pkg;

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} mau_state_t;

  // Byte lanes of a wide access, little-endian.
  localparam int LO_LANE = 0;
  localparam int HI_LANE = 1;

endpackage

// File: rtl/mem_access_unit.sv
// Load/store sequencer: splits 8/16-bit core requests into per-cycle byte
// accesses on a single-port data memory and returns a one-cycle response.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int W = 8,
  parameter int A = 8
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic           ReqValid,
  input  logic           ReqWrite,
  input  logic           ReqWide,
  input  logic [A-1:0]   ReqAddr,
  input  logic [2*W-1:0] ReqWData,
  output logic           ReqReady,
  output logic           RespValid,
  output logic [2*W-1:0] RespRData,
  output logic           MemWriteEn,
  output logic [A-1:0]   MemAddress,
  output logic [W-1:0]   MemWData,
  input  logic [W-1:0]   MemRData
);

  mau_state_t          state_q, state_d;
  logic [A-1:0]        addr_q;
  logic                write_q;
  logic                wide_q;
  logic [1:0][W-1:0]   wdata_q;
  logic [1:0][W-1:0]   rdata_q;

  // State register; async reset drops any in-flight access immediately,
  // which also kills MemWriteEn since it is decoded from state.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state and memory-side outputs, decoded from state and latched
  // request fields only (never combinationally from Req*).
  always_comb begin
    state_d    = state_q;
    ReqReady   = 1'b0;
    RespValid  = 1'b0;
    RespRData  = '0;
    MemWriteEn = 1'b0;
    MemAddress = '0;
    MemWData   = '0;
    case (state_q)
      IDLE: begin
        ReqReady = 1'b1;
        if (ReqValid) state_d = ACC0;
      end
      ACC0: begin
        MemAddress = addr_q;
        MemWriteEn = write_q;
        MemWData   = wdata_q[LO_LANE];
        state_d    = wide_q ? ACC1 : RESP;
      end
      ACC1: begin
        // High byte lives at the next address; wraps at the top of memory.
        MemAddress = addr_q + A'(1);
        MemWriteEn = write_q;
        MemWData   = wdata_q[HI_LANE];
        state_d    = RESP;
      end
      RESP: begin
        RespValid = 1'b1;
        RespRData = rdata_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request capture and load-data assembly. Read data is cleared on accept
  // so narrow loads zero-extend and stores respond with 0.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      wide_q  <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (ReqValid) begin
          addr_q  <= ReqAddr;
          write_q <= ReqWrite;
          wide_q  <= ReqWide;
          wdata_q <= ReqWData;
          rdata_q <= '0;
        end
        ACC0: if (!write_q) rdata_q[LO_LANE] <= MemRData;
        ACC1: if (!write_q) rdata_q[HI_LANE] <= MemRData;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: behavioural DataMem responder, a transaction-level
// expectation queue checked every cycle, directed cases and random traffic.
module tb_mem_access_unit;

  logic        Clk, Reset;
  logic        ReqValid, ReqWrite, ReqWide;
  logic [7:0]  ReqAddr;
  logic [15:0] ReqWData;
  logic        ReqReady, RespValid;
  logic [15:0] RespRData;
  logic        MemWriteEn;
  logic [7:0]  MemAddress, MemWData, MemRData;

  mem_access_unit #(.W(8), .A(8)) dut (
    .Clk(Clk), .Reset(Reset),
    .ReqValid(ReqValid), .ReqWrite(ReqWrite), .ReqWide(ReqWide),
    .ReqAddr(ReqAddr), .ReqWData(ReqWData),
    .ReqReady(ReqReady), .RespValid(RespValid), .RespRData(RespRData),
    .MemWriteEn(MemWriteEn), .MemAddress(MemAddress), .MemWData(MemWData),
    .MemRData(MemRData)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // DataMem responder: combinational read, write on clock edge.
  logic [7:0] mem [256] = '{default: 8'h00};
  assign MemRData = mem[MemAddress];
  always @(posedge Clk) if (MemWriteEn) mem[MemAddress] <= MemWData;

  int tests = 0;
  int fails = 0;

  // Expected per-cycle view of the DUT outputs.
  typedef struct packed {
    logic        rdy;
    logic        rv;
    logic [15:0] rdata;
    logic        we;
    logic [7:0]  addr;
    logic [7:0]  wdata;
  } exp_t;

  localparam exp_t IDLE_E = '{rdy: 1'b1, rv: 1'b0, rdata: 16'h0, we: 1'b0, addr: 8'h0, wdata: 8'h0};

  exp_t       exp_q [$];
  logic [7:0] ref_mem [256] = '{default: 8'h00};

  // Model: an accepted request expands into one bus cycle per byte followed
  // by a response cycle; the memory image changes when a write cycle ends.
  always @(posedge Clk or posedge Reset) begin
    exp_t e;
    logic [7:0] a1;
    logic [15:0] rd;
    if (Reset) begin
      exp_q.delete();
    end else if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e.we) ref_mem[e.addr] = e.wdata;
    end else if (ReqValid) begin
      a1 = ReqAddr + 8'd1;
      exp_q.push_back('{rdy: 1'b0, rv: 1'b0, rdata: 16'h0, we: ReqWrite, addr: ReqAddr, wdata: ReqWData[7:0]});
      if (ReqWide)
        exp_q.push_back('{rdy: 1'b0, rv: 1'b0, rdata: 16'h0, we: ReqWrite, addr: a1, wdata: ReqWData[15:8]});
      rd = 16'h0;
      if (!ReqWrite) rd = {ReqWide ? ref_mem[a1] : 8'h00, ref_mem[ReqAddr]};
      exp_q.push_back('{rdy: 1'b0, rv: 1'b1, rdata: rd, we: 1'b0, addr: 8'h0, wdata: 8'h0});
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge Clk) begin
    exp_t ex, ac;
    ex = (exp_q.size() > 0) ? exp_q[0] : IDLE_E;
    ac = '{rdy: ReqReady, rv: RespValid, rdata: RespRData, we: MemWriteEn, addr: MemAddress, wdata: MemWData};
    tests++;
    if (ac !== ex) begin
      fails++;
      $display("FAIL cycle t=%0t got rdy=%b rv=%b rdata=%h we=%b addr=%h wd=%h expected rdy=%b rv=%b rdata=%h we=%b addr=%h wd=%h",
               $time, ac.rdy, ac.rv, ac.rdata, ac.we, ac.addr, ac.wdata,
               ex.rdy, ex.rv, ex.rdata, ex.we, ex.addr, ex.wdata);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one request, hold it until accepted, wait (bounded) for the response.
  // lat counts cycles after the accept edge until RespValid is seen.
  task automatic do_req(input logic w, input logic wide, input logic [7:0] a,
                        input logic [15:0] d, output logic [15:0] rd, output int lat);
    bit got;
    @(posedge Clk); #1;
    ReqValid = 1'b1; ReqWrite = w; ReqWide = wide; ReqAddr = a; ReqWData = d;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      if (ReqReady) begin got = 1; break; end
    end
    if (!got) check("ready_timeout", 32'd0, 32'd1);
    @(posedge Clk); #1;
    ReqValid = 1'b0; ReqWrite = $urandom_range(0, 1); ReqWide = $urandom_range(0, 1);
    ReqAddr = 8'($urandom); ReqWData = 16'($urandom);
    rd = 16'h0; lat = 0; got = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      lat++;
      if (RespValid) begin rd = RespRData; got = 1; break; end
    end
    if (!got) check("resp_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    logic [15:0] rd, r1, r2;
    int lat, busy, diffs;
    bit got;

    Reset = 1'b1; ReqValid = 1'b0; ReqWrite = 1'b0; ReqWide = 1'b0;
    ReqAddr = 8'h0; ReqWData = 16'h0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    check("reset_ready", {31'd0, ReqReady}, 32'd1);
    check("reset_outs", {RespValid, MemWriteEn, RespRData, MemAddress}, 32'd0);
    @(posedge Clk); #1 Reset = 1'b0;

    // Narrow store then load.
    do_req(1'b1, 1'b0, 8'h10, 16'h005A, rd, lat);
    check("n_store_mem", {24'd0, mem[8'h10]}, 32'h5A);
    do_req(1'b0, 1'b0, 8'h10, 16'hC3C3, rd, lat);
    check("n_load_data", {16'd0, rd}, 32'h005A);
    check("n_load_lat", lat, 32'd2);

    // Wide store/load, little-endian.
    do_req(1'b1, 1'b1, 8'h20, 16'hBEEF, rd, lat);
    check("w_store_lo", {24'd0, mem[8'h20]}, 32'hEF);
    check("w_store_hi", {24'd0, mem[8'h21]}, 32'hBE);
    check("w_store_resp", {16'd0, rd}, 32'h0);
    do_req(1'b0, 1'b1, 8'h20, 16'h0000, rd, lat);
    check("w_load_data", {16'd0, rd}, 32'hBEEF);
    check("w_load_lat", lat, 32'd3);

    // Address wrap on the high byte.
    do_req(1'b1, 1'b1, 8'hFF, 16'h1234, rd, lat);
    check("wrap_lo", {24'd0, mem[8'hFF]}, 32'h34);
    check("wrap_hi", {24'd0, mem[8'h00]}, 32'h12);
    do_req(1'b0, 1'b1, 8'hFF, 16'h0000, rd, lat);
    check("wrap_load", {16'd0, rd}, 32'h1234);

    // Narrow load zero-extends.
    do_req(1'b1, 1'b1, 8'h30, 16'h8877, rd, lat);
    do_req(1'b0, 1'b0, 8'h30, 16'hFFFF, rd, lat);
    check("n_zero_ext", {16'd0, rd}, 32'h0077);

    // Second request held during a wide load is not taken until idle.
    @(posedge Clk); #1;
    ReqValid = 1'b1; ReqWrite = 1'b0; ReqWide = 1'b1; ReqAddr = 8'h20; ReqWData = 16'h0;
    @(posedge Clk); #1;
    ReqWide = 1'b0; ReqAddr = 8'h10; ReqWData = 16'h7E7E;
    busy = 0; r1 = 16'h0;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      if (RespValid) r1 = RespRData;
      if (!ReqReady) busy++;
      else break;
    end
    check("busy_cycles", busy, 32'd3);
    check("busy_resp1", {16'd0, r1}, 32'hBEEF);
    @(posedge Clk); #1 ReqValid = 1'b0;
    r2 = 16'h0; got = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      if (RespValid) begin r2 = RespRData; got = 1; break; end
    end
    check("busy_resp2_seen", {31'd0, got}, 32'd1);
    check("busy_resp2", {16'd0, r2}, 32'h005A);

    // Reset during the high-byte write of a wide store.
    do_req(1'b1, 1'b0, 8'h41, 16'h0011, rd, lat);
    @(posedge Clk); #1;
    ReqValid = 1'b1; ReqWrite = 1'b1; ReqWide = 1'b1; ReqAddr = 8'h40; ReqWData = 16'hAAAA;
    @(posedge Clk); #1 ReqValid = 1'b0;
    @(posedge Clk); #1 Reset = 1'b1;
    #1;
    check("rst_we", {31'd0, MemWriteEn}, 32'd0);
    check("rst_ready", {31'd0, ReqReady}, 32'd1);
    check("rst_rv", {31'd0, RespValid}, 32'd0);
    check("rst_rdata", {16'd0, RespRData}, 32'd0);
    check("rst_addr_wd", {16'd0, MemAddress, MemWData}, 32'd0);
    @(posedge Clk); #1 Reset = 1'b0;
    check("rst_mem41", {24'd0, mem[8'h41]}, 32'h11);
    check("rst_mem40", {24'd0, mem[8'h40]}, 32'hAA);
    do_req(1'b0, 1'b1, 8'h40, 16'h0, rd, lat);
    check("rst_after_load", {16'd0, rd}, 32'h11AA);
    check("rst_after_lat", lat, 32'd3);

    // Random traffic; per-cycle model does the data checks.
    for (int t = 0; t < 300; t++) begin
      logic w, wd;
      w = 1'($urandom_range(0, 1));
      wd = 1'($urandom_range(0, 1));
      do_req(w, wd, 8'($urandom), 16'($urandom), rd, lat);
      check("rand_lat", lat, wd ? 32'd3 : 32'd2);
      repeat ($urandom_range(0, 2)) @(posedge Clk);
    end

    repeat (2) @(posedge Clk);
    diffs = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) diffs++;
    check("mem_image", diffs, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
